room_plant: RTL and testbench

ROOM_PLANT -- requirements
Module: room_plant

---
 rtl/room_plant.sv | 105 ++++++++++
 tb/tb_room_plant.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/room_plant.sv
// rtl/room_plant.sv - thermal room model driven by thermostat heat/cool demands
// Updates once per prescaled tick; conflicting demands held long enough latch a sticky fault.
module room_plant #(
  parameter int         TICK_DIV    = 4,
  parameter int         DRIFT_DIV   = 4,
  parameter int         FAULT_LIMIT = 3,
  parameter logic [4:0] INIT_TEMP   = 5'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heating,
  input  logic       cooling,
  input  logic [4:0] ambient,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic [1:0] mode,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HEAT  = 2'b01,
    COOL  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] DRIFT_TOP = 4'(DRIFT_DIV);
  localparam logic [3:0] FAULT_TOP = 4'(FAULT_LIMIT);

  state_t     state, next_state;
  logic [7:0] presc;
  logic [3:0] drift_cnt, next_drift;
  logic [3:0] conf_cnt, next_conf;
  logic [4:0] next_temp;
  logic       tick;

  assign tick  = (presc == TICK_LAST);
  assign mode  = state;
  assign fault = (state == FAULT);

  // Counters only ever reach their limits, so 4-bit increments cannot wrap.
  always_comb begin
    next_state = state;
    next_temp  = temperature;
    next_drift = drift_cnt;
    next_conf  = conf_cnt;
    if (state != FAULT) begin
      if (heating && cooling) begin
        next_conf = conf_cnt + 4'd1;
        if (conf_cnt + 4'd1 == FAULT_TOP)
          next_state = FAULT;
      end else begin
        next_conf = 4'd0;
        case ({heating, cooling})
          2'b10: begin
            next_state = HEAT;
            if (temperature != 5'd31)
              next_temp = temperature + 5'd1;
          end
          2'b01: begin
            next_state = COOL;
            if (temperature != 5'd0)
              next_temp = temperature - 5'd1;
          end
          default: begin
            next_state = IDLE;
            if (drift_cnt + 4'd1 == DRIFT_TOP) begin
              next_drift = 4'd0;
              if (temperature < ambient)
                next_temp = temperature + 5'd1;
              else if (temperature > ambient)
                next_temp = temperature - 5'd1;
            end else begin
              next_drift = drift_cnt + 4'd1;
            end
          end
        endcase
      end
      if (next_state != IDLE)
        next_drift = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      temperature <= INIT_TEMP;
      temp_valid  <= 1'b0;
      presc       <= 8'd0;
      drift_cnt   <= 4'd0;
      conf_cnt    <= 4'd0;
    end else begin
      temp_valid <= tick;
      presc      <= tick ? 8'd0 : presc + 8'd1;
      if (tick) begin
        state       <= next_state;
        temperature <= next_temp;
        drift_cnt   <= next_drift;
        conf_cnt    <= next_conf;
      end
    end
  end

endmodule

// File: tb/tb_room_plant.sv
// tb/tb_room_plant.sv - scoreboard bench for room_plant
module tb_room_plant;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic [4:0] ambient = 5'd15;
  logic [4:0] temperature;
  logic       temp_valid;
  logic [1:0] mode;
  logic       fault;

  typedef struct {
    logic [4:0] t;
    logic [1:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  room_plant dut (
    .clk         (clk),
    .rst         (rst),
    .heating     (heating),
    .cooling     (cooling),
    .ambient     (ambient),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .mode        (mode),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every temp_valid pulse consumes exactly one expected tick result.
  always @(negedge clk) begin
    if (temp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got temp %0d mode %0d expected no pulse", temperature, mode);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_temp", int'(temperature), int'(e.t));
        check("tick_mode", int'(mode), int'(e.m));
        check("tick_fault", int'(fault), int'(e.m == 2'b11));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_temp", int'(temperature), 15);
    check("rst_mode", int'(mode), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_valid", int'(temp_valid), 0);
    rst = 1'b0;
  endtask

  // One full tick period; called at a negedge aligned with the prescaler phase.
  task automatic do_tick(input logic h, input logic c, input logic [4:0] amb,
                         input logic [4:0] et, input logic [1:0] em);
    exp_t e;
    heating = h;
    cooling = c;
    ambient = amb;
    e.t = et;
    e.m = em;
    exp_q.push_back(e);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_tick(input logic [4:0] amb, input logic [4:0] et, input logic [1:0] em);
    exp_t e;
    heating = 1'b0;
    cooling = 1'b0;
    ambient = amb;
    e.t = et;
    e.m = em;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk) heating = 1'b1;
    @(posedge clk);
    @(negedge clk) heating = 1'b0;
    cooling = 1'b1;
    @(posedge clk);
    @(negedge clk) cooling = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Heat from 15 up through saturation at 31.
    for (int t = 16; t <= 31; t++) do_tick(1'b1, 1'b0, 5'd15, 5'(t), 2'b01);
    do_tick(1'b1, 1'b0, 5'd15, 5'd31, 2'b01);
    do_tick(1'b1, 1'b0, 5'd15, 5'd31, 2'b01);

    // Cool from 31 down to 0 and hold there.
    for (int t = 30; t >= 0; t--) do_tick(1'b0, 1'b1, 5'd15, 5'(t), 2'b10);
    do_tick(1'b0, 1'b1, 5'd15, 5'd0, 2'b10);

    // Ambient drift: one degree every four idle ticks, downward then upward.
    do_reset();
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0, 5'd10, 5'd15, 2'b00);
    do_tick(1'b0, 1'b0, 5'd10, 5'd14, 2'b00);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0, 5'd10, 5'd14, 2'b00);
    do_tick(1'b0, 1'b0, 5'd10, 5'd13, 2'b00);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0, 5'd31, 5'd13, 2'b00);
    do_tick(1'b0, 1'b0, 5'd31, 5'd14, 2'b00);

    do_reset();
    for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0, 5'd15, 5'd15, 2'b00);

    // Demands that toggle only between ticks must be ignored.
    pulse_tick(5'd15, 5'd15, 2'b00);
    pulse_tick(5'd15, 5'd15, 2'b00);

    // Conflict escalation to a sticky fault.
    do_reset();
    do_tick(1'b1, 1'b1, 5'd15, 5'd15, 2'b00);
    do_tick(1'b1, 1'b1, 5'd15, 5'd15, 2'b00);
    do_tick(1'b1, 1'b1, 5'd15, 5'd15, 2'b11);
    do_tick(1'b1, 1'b0, 5'd15, 5'd15, 2'b11);
    do_tick(1'b0, 1'b1, 5'd0,  5'd15, 2'b11);

    // A clean tick clears the conflict count.
    do_reset();
    do_tick(1'b1, 1'b1, 5'd15, 5'd15, 2'b00);
    do_tick(1'b1, 1'b1, 5'd15, 5'd15, 2'b00);
    do_tick(1'b1, 1'b0, 5'd15, 5'd16, 2'b01);
    do_tick(1'b1, 1'b1, 5'd15, 5'd16, 2'b01);
    do_tick(1'b1, 1'b1, 5'd15, 5'd16, 2'b01);
    do_tick(1'b1, 1'b0, 5'd15, 5'd17, 2'b01);

    // Reset one cycle before a tick while heating at 20.
    for (int t = 18; t <= 20; t++) do_tick(1'b1, 1'b0, 5'd15, 5'(t), 2'b01);
    heating = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_temp", int'(temperature), 15);
    check("midrst_valid", int'(temp_valid), 0);
    check("midrst_mode", int'(mode), 0);
    rst = 1'b0;
    do_tick(1'b1, 1'b0, 5'd15, 5'd16, 2'b01);
    do_tick(1'b1, 1'b0, 5'd15, 5'd17, 2'b01);

    repeat (2) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
